issue_ctrl: RTL and testbench

- Scoreboard-based issue controller between the decode stage and the execute stage of the in-order RV64I core.
- Takes the decode stage's register-enable/address outputs and the execute stage's redirect and writeback reports.
- Decides each cycle whether the decoded instruction issues, stalls or is flushed.
- Enforces RAW/WAW hazards, an in-flight limit, fence draining and a post-redirect flush window.

---
 rtl/issue_ctrl.sv | 160 ++++++++++++++++
 tb/tb_issue_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// -----------------------------------------------------------------------------
// issue_ctrl
// Scoreboard-based issue controller between the decode and execute stages of
// the in-order RV64I core. Each cycle it decides whether the decoded
// instruction issues, stalls, or is flushed. It covers these cases:
//   - RAW/WAW hazards against a per-register busy scoreboard
//   - a limit on issued-but-not-retired instructions
//   - FENCE draining
//   - a flush window after a taken branch or jump
//
// Optional feature: define ISSUE_STALL_STATS_EN to build a free-running
// stall-cycle counter on perf_stall_cnt. When the macro is undefined, that
// output is tied to zero and the counter has no flops.
// -----------------------------------------------------------------------------
module issue_ctrl #(
    parameter int MAX_INFLIGHT     = 4,   // 2..15
    parameter int REDIRECT_PENALTY = 2    // 1..7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        rs1_r_ena,
    input  logic [4:0]  rs1_r_addr,
    input  logic        rs2_r_ena,
    input  logic [4:0]  rs2_r_addr,
    input  logic        rd_w_ena,
    input  logic [4:0]  rd_w_addr,
    input  logic        is_fence,
    input  logic        ex_ready,
    input  logic        redirect,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic        retire,
    output logic        issue,
    output logic        id_stall,
    output logic        id_flush,
    output logic [31:0] busy_vec,
    output logic [3:0]  inflight_cnt,
    output logic [31:0] perf_stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT       = 4'(MAX_INFLIGHT);
    // The redirect cycle itself is the first flush cycle, so FLUSH covers the rest.
    localparam logic [2:0] PEN_LOAD      = 3'(REDIRECT_PENALTY - 1);
    localparam state_t     REDIRECT_NEXT = (REDIRECT_PENALTY > 1) ? FLUSH : RUN;

    state_t      state, state_next;
    logic [2:0]  flush_cnt, flush_cnt_next;
    logic [31:0] wb_mask, set_mask, eff_busy, busy_next;
    logic [3:0]  inflight_next;
    logic        hazard, full, drain_done;

    // Hazard, capacity and drain conditions seen by the issue decision.
    always_comb begin
        wb_mask    = wb_valid ? (32'd1 << wb_addr) : 32'd0;
        // A register written back this cycle is already free for a reader.
        eff_busy   = busy_vec & ~wb_mask;
        hazard     = (rs1_r_ena & eff_busy[rs1_r_addr]) |
                     (rs2_r_ena & eff_busy[rs2_r_addr]) |
                     (rd_w_ena  & eff_busy[rd_w_addr]);
        full       = (inflight_cnt == MAX_CNT) & ~retire;
        drain_done = (busy_vec == 32'd0) && (inflight_cnt == 4'd0) && ex_ready;
    end

    // Next-state and issue/stall/flush decisions; a redirect overrides every state.
    always_comb begin
        // NOTE: every output gets a default first, so no path infers a latch.
        state_next     = state;
        flush_cnt_next = flush_cnt;
        issue          = 1'b0;
        id_stall       = 1'b0;
        id_flush       = 1'b0;
        if (rst) begin
            // Outputs stay quiet while reset is held, whatever decode presents.
        end else if (redirect) begin
            id_flush       = 1'b1;
            flush_cnt_next = PEN_LOAD;
            state_next     = REDIRECT_NEXT;
        end else begin
            unique case (state)
                RUN: begin
                    issue    = id_valid & ex_ready & ~hazard & ~full & ~is_fence;
                    id_stall = id_valid & ~issue;
                    if (id_valid & is_fence) begin
                        state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    // The fence issues on the cycle the pipeline is empty.
                    if (drain_done) begin
                        issue      = 1'b1;
                        state_next = RUN;
                    end else begin
                        id_stall = 1'b1;
                    end
                end
                FLUSH: begin
                    id_flush = 1'b1;
                    if (flush_cnt <= 3'd1) begin
                        flush_cnt_next = 3'd0;
                        state_next     = RUN;
                    end else begin
                        flush_cnt_next = flush_cnt - 3'd1;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    // Scoreboard and in-flight bookkeeping for the next cycle.
    always_comb begin
        set_mask = (issue & rd_w_ena & (rd_w_addr != 5'd0)) ? (32'd1 << rd_w_addr) : 32'd0;
        // Clear first, then set, so a same-index set wins; x0 is never busy.
        busy_next = ((busy_vec & ~wb_mask) | set_mask) & ~32'd1;

        inflight_next = inflight_cnt;
        if (issue & ~retire) begin
            inflight_next = inflight_cnt + 4'd1;
        end else if (~issue & retire & (inflight_cnt != 4'd0)) begin
            inflight_next = inflight_cnt - 4'd1;
        end
    end

    // State register, flush counter, scoreboard and in-flight count.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state        <= RUN;
            flush_cnt    <= 3'd0;
            busy_vec     <= 32'd0;
            inflight_cnt <= 4'd0;
        end else begin
            state        <= state_next;
            flush_cnt    <= flush_cnt_next;
            busy_vec     <= busy_next;
            inflight_cnt <= inflight_next;
        end
    end

`ifdef ISSUE_STALL_STATS_EN
    // Stall-cycle counter; it wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= 32'd0;
        end else if (id_stall) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_issue_ctrl
// Self-checking bench for issue_ctrl. It contains directed scenarios for:
//   - RAW hazards and writeback bypass
//   - set-wins on the scoreboard and x0 handling
//   - the in-flight limit and the retire-at-zero case
//   - fence draining
//   - redirect flush windows
//   - async reset
//   - the stall counter
// Randomized traffic is checked against a behavioural model.
// -----------------------------------------------------------------------------
module tb_issue_ctrl;

    localparam int MAX_INF = 4;
    localparam int PEN     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, rs1_r_ena, rs2_r_ena, rd_w_ena, is_fence;
    logic [4:0]  rs1_r_addr, rs2_r_addr, rd_w_addr, wb_addr;
    logic        ex_ready, redirect, wb_valid, retire;
    logic        issue, id_stall, id_flush;
    logic [31:0] busy_vec, perf_stall_cnt;
    logic [3:0]  inflight_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: busy set, outstanding count, fence pending, flush cycles left.
    bit [31:0]   m_busy;
    int          m_inflight;
    bit          m_drain;
    int          m_flush_left;
    int unsigned m_stalls;
    bit          e_issue, e_stall, e_flush;

    issue_ctrl #(.MAX_INFLIGHT(MAX_INF), .REDIRECT_PENALTY(PEN)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid),
        .rs1_r_ena(rs1_r_ena), .rs1_r_addr(rs1_r_addr),
        .rs2_r_ena(rs2_r_ena), .rs2_r_addr(rs2_r_addr),
        .rd_w_ena(rd_w_ena), .rd_w_addr(rd_w_addr),
        .is_fence(is_fence), .ex_ready(ex_ready), .redirect(redirect),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .retire(retire),
        .issue(issue), .id_stall(id_stall), .id_flush(id_flush),
        .busy_vec(busy_vec), .inflight_cnt(inflight_cnt),
        .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_valid = 0; rs1_r_ena = 0; rs2_r_ena = 0; rd_w_ena = 0; is_fence = 0;
        rs1_r_addr = 0; rs2_r_addr = 0; rd_w_addr = 0; wb_addr = 0;
        ex_ready = 1; redirect = 0; wb_valid = 0; retire = 0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_inflight = 0; m_drain = 0; m_flush_left = 0; m_stalls = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Expected combinational outputs for the current inputs and model state.
    task automatic model_eval();
        bit [31:0] eb;
        bit hz, fl;
        eb = m_busy;
        if (wb_valid) eb[wb_addr] = 1'b0;
        hz = (rs1_r_ena && eb[rs1_r_addr]) || (rs2_r_ena && eb[rs2_r_addr]) ||
             (rd_w_ena && eb[rd_w_addr]);
        fl = (m_inflight == MAX_INF) && !retire;
        e_issue = 0; e_stall = 0; e_flush = 0;
        if (redirect || m_flush_left > 0) begin
            e_flush = 1;
        end else if (m_drain) begin
            if (m_busy == 0 && m_inflight == 0 && ex_ready) e_issue = 1;
            else e_stall = 1;
        end else begin
            e_issue = id_valid && ex_ready && !hz && !fl && !is_fence;
            e_stall = id_valid && !e_issue;
        end
    endtask

    // Advance the model across one clock edge.
    task automatic model_commit();
        if (redirect) begin
            m_flush_left = PEN - 1;
            m_drain = 0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (m_drain) begin
            if (e_issue) m_drain = 0;
        end else if (id_valid && is_fence) begin
            m_drain = 1;
        end
        if (wb_valid) m_busy[wb_addr] = 1'b0;
        if (e_issue && rd_w_ena && rd_w_addr != 0) m_busy[rd_w_addr] = 1'b1;
        if (e_issue && !retire) m_inflight++;
        else if (!e_issue && retire && m_inflight > 0) m_inflight--;
        if (e_stall) m_stalls++;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; id_valid = 1; ex_ready = 1;
        @(negedge clk);
        checks++; if (issue !== 1'b0) begin errors++; $display("FAIL reset_issue: got %0b want 0", issue); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", id_stall); end
        checks++; if (id_flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0b want 0", id_flush); end
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
        checks++; if (inflight_cnt !== 4'd0) begin errors++; $display("FAIL reset_inflight: got %0d want 0", inflight_cnt); end
        checks++; if (perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_perf: got %0d want 0", perf_stall_cnt); end
        tick();
        rst = 0;
        idle_inputs();
    endtask

    task automatic test_raw();
        apply_reset();
        id_valid = 1; rd_w_ena = 1; rd_w_addr = 5;
        @(negedge clk);
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL raw_first_issue: got %0b want 1", issue); end
        tick();
        rd_w_ena = 0; rs1_r_ena = 1; rs1_r_addr = 5;
        @(negedge clk);
        checks++; if (busy_vec[5] !== 1'b1) begin errors++; $display("FAIL raw_busy5: got %0b want 1", busy_vec[5]); end
        checks++; if (id_stall !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL raw_stall: got stall=%0b issue=%0b want 1/0", id_stall, issue); end
        tick();
        wb_valid = 1; wb_addr = 5;
        @(negedge clk);
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL raw_wb_bypass: got %0b want 1", issue); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL raw_busy_after: got %h want 0", busy_vec); end
        tick();
    endtask

    task automatic test_set_wins();
        apply_reset();
        id_valid = 1; rd_w_ena = 1; rd_w_addr = 0;
        @(negedge clk);
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL x0_issue: got %0b want 1", issue); end
        tick();
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL x0_busy: got %h want 0", busy_vec); end
        rd_w_addr = 7; wb_valid = 1; wb_addr = 7;
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (busy_vec !== 32'h80) begin errors++; $display("FAIL set_wins_busy: got %h want 00000080", busy_vec); end
        tick();
    endtask

    task automatic test_inflight();
        apply_reset();
        id_valid = 1;
        for (int i = 0; i < MAX_INF; i++) begin
            @(negedge clk);
            checks++; if (issue !== 1'b1) begin errors++; $display("FAIL fill_issue_%0d: got %0b want 1", i, issue); end
            tick();
        end
        @(negedge clk);
        checks++; if (inflight_cnt !== 4'(MAX_INF)) begin errors++; $display("FAIL full_count: got %0d want %0d", inflight_cnt, MAX_INF); end
        checks++; if (issue !== 1'b0 || id_stall !== 1'b1) begin errors++; $display("FAIL full_stall: got issue=%0b stall=%0b want 0/1", issue, id_stall); end
        tick();
        retire = 1;
        @(negedge clk);
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL full_retire_issue: got %0b want 1", issue); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (inflight_cnt !== 4'(MAX_INF)) begin errors++; $display("FAIL full_count_kept: got %0d want %0d", inflight_cnt, MAX_INF); end
        apply_reset();
        retire = 1;
        tick();
        checks++; if (inflight_cnt !== 4'd0) begin errors++; $display("FAIL retire_at_zero: got %0d want 0", inflight_cnt); end
        idle_inputs();
    endtask

    task automatic test_fence();
        apply_reset();
        id_valid = 1; rd_w_ena = 1; rd_w_addr = 3;
        tick();
        rd_w_ena = 0;
        tick();
        is_fence = 1;
        @(negedge clk);
        checks++; if (issue !== 1'b0 || id_stall !== 1'b1) begin errors++; $display("FAIL fence_enter: got issue=%0b stall=%0b want 0/1", issue, id_stall); end
        tick();
        wb_valid = 1; wb_addr = 3; retire = 1;
        @(negedge clk);
        checks++; if (issue !== 1'b0 || id_stall !== 1'b1) begin errors++; $display("FAIL fence_drain1: got issue=%0b stall=%0b want 0/1", issue, id_stall); end
        tick();
        wb_valid = 0;
        @(negedge clk);
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL fence_drain2: got stall=%0b want 1", id_stall); end
        tick();
        retire = 0;
        @(negedge clk);
        checks++; if (issue !== 1'b1 || id_stall !== 1'b0) begin errors++; $display("FAIL fence_issue: got issue=%0b stall=%0b want 1/0", issue, id_stall); end
        tick();
        is_fence = 0;
        @(negedge clk);
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL fence_back_to_run: got %0b want 1", issue); end
        tick();
        idle_inputs();
    endtask

    task automatic test_redirect();
        apply_reset();
        id_valid = 1; rd_w_ena = 1; rd_w_addr = 5;
        tick();
        rd_w_ena = 0; rs1_r_ena = 1; rs1_r_addr = 5;
        @(negedge clk);
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL redir_pre_stall: got %0b want 1", id_stall); end
        tick();
        redirect = 1;
        @(negedge clk);
        checks++; if ({id_flush, issue, id_stall} !== 3'b100) begin errors++; $display("FAIL redir_cycle1: got flush/issue/stall=%b want 100", {id_flush, issue, id_stall}); end
        tick();
        redirect = 0;
        @(negedge clk);
        checks++; if ({id_flush, issue, id_stall} !== 3'b100) begin errors++; $display("FAIL redir_cycle2: got flush/issue/stall=%b want 100", {id_flush, issue, id_stall}); end
        tick();
        @(negedge clk);
        checks++; if (id_flush !== 1'b0 || id_stall !== 1'b1) begin errors++; $display("FAIL redir_end: got flush=%0b stall=%0b want 0/1", id_flush, id_stall); end
        checks++; if (busy_vec[5] !== 1'b1) begin errors++; $display("FAIL redir_keeps_busy: got %0b want 1", busy_vec[5]); end
        tick();
        redirect = 1;
        tick();
        @(negedge clk);
        checks++; if (id_flush !== 1'b1) begin errors++; $display("FAIL redir2_cycle2: got %0b want 1", id_flush); end
        tick();
        redirect = 0;
        @(negedge clk);
        checks++; if (id_flush !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL redir2_cycle3: got flush=%0b issue=%0b want 1/0", id_flush, issue); end
        tick();
        @(negedge clk);
        checks++; if (id_flush !== 1'b0) begin errors++; $display("FAIL redir2_end: got %0b want 0", id_flush); end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        bit [31:0] exp_perf;
        apply_reset();
        for (int n = 0; n < 1500; n++) begin
            id_valid   = ($urandom_range(0, 9) < 7);
            rs1_r_ena  = $urandom_range(0, 1) == 1;
            rs2_r_ena  = $urandom_range(0, 1) == 1;
            rd_w_ena   = $urandom_range(0, 1) == 1;
            rs1_r_addr = 5'($urandom_range(0, 7));
            rs2_r_addr = 5'($urandom_range(0, 7));
            rd_w_addr  = 5'($urandom_range(0, 7));
            is_fence   = ($urandom_range(0, 19) == 0);
            ex_ready   = ($urandom_range(0, 9) < 8);
            redirect   = ($urandom_range(0, 19) == 0);
            wb_valid   = ($urandom_range(0, 9) < 4);
            wb_addr    = 5'($urandom_range(0, 7));
            retire     = ($urandom_range(0, 9) < 4);
            @(negedge clk);
            model_eval();
`ifdef ISSUE_STALL_STATS_EN
            exp_perf = m_stalls;
`else
            exp_perf = 32'd0;
`endif
            checks++; if (issue !== e_issue) begin errors++; $display("FAIL rnd_issue[%0d]: got %0b want %0b", n, issue, e_issue); end
            checks++; if (id_stall !== e_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %0b want %0b", n, id_stall, e_stall); end
            checks++; if (id_flush !== e_flush) begin errors++; $display("FAIL rnd_flush[%0d]: got %0b want %0b", n, id_flush, e_flush); end
            checks++; if (busy_vec !== m_busy) begin errors++; $display("FAIL rnd_busy[%0d]: got %h want %h", n, busy_vec, m_busy); end
            checks++; if (inflight_cnt !== 4'(m_inflight)) begin errors++; $display("FAIL rnd_inflight[%0d]: got %0d want %0d", n, inflight_cnt, m_inflight); end
            checks++; if (perf_stall_cnt !== exp_perf) begin errors++; $display("FAIL rnd_perf[%0d]: got %0d want %0d", n, perf_stall_cnt, exp_perf); end
            model_commit();
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        apply_reset();
        id_valid = 1; rd_w_ena = 1; rd_w_addr = 3;
        tick();
        rd_w_addr = 5;
        tick();
        rd_w_ena = 0; is_fence = 1;
        tick();
        #1;
        checks++; if (busy_vec !== 32'h28 || id_stall !== 1'b1) begin errors++; $display("FAIL drain_setup: got busy=%h stall=%0b want 00000028/1", busy_vec, id_stall); end
        rst = 1;
        #1;
        checks++; if ({issue, id_stall, id_flush} !== 3'b000) begin errors++; $display("FAIL async_rst_ctrl: got issue/stall/flush=%b want 000", {issue, id_stall, id_flush}); end
        checks++; if (busy_vec !== 32'd0 || inflight_cnt !== 4'd0) begin errors++; $display("FAIL async_rst_state: got busy=%h inflight=%0d want 0/0", busy_vec, inflight_cnt); end
        checks++; if (perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL async_rst_perf: got %0d want 0", perf_stall_cnt); end
        idle_inputs();
        rst = 0;
        wb_valid = 1; wb_addr = 3;
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL stale_wb: got %h want 0", busy_vec); end
        tick();
    endtask

    task automatic test_stall_stats();
        bit [31:0] exp_perf;
        apply_reset();
        id_valid = 1; ex_ready = 0;
        repeat (10) tick();
        idle_inputs();
`ifdef ISSUE_STALL_STATS_EN
        exp_perf = 32'd10;
`else
        exp_perf = 32'd0;
`endif
        @(negedge clk);
        checks++; if (perf_stall_cnt !== exp_perf) begin errors++; $display("FAIL stall_stats: got %0d want %0d", perf_stall_cnt, exp_perf); end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_raw();
        test_set_wins();
        test_inflight();
        test_fence();
        test_redirect();
        test_random();
        test_async_reset();
        test_stall_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
